// File: rtl/decoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder_pkg : shared constants and helpers for the streaming decoder
// Rev 1.0
// ---------------------------------------------------------------------------
package decoder_pkg;

  localparam int CODE_W_DEFAULT = 1;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Decoded output is limited to 32 lines, so CODE_W must stay <= 5.
  function automatic logic [31:0] onehot(input int unsigned code);
    return 32'd1 << code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO, occupancy counter resolves full/empty
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo
  import decoder_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int          AW       = ptr_w(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             w_push, w_pop;

  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/decoder12_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decoder12_stream : FIFO-buffered binary-to-one-hot decoder, valid/ready
// Rev 1.0
// ---------------------------------------------------------------------------
module decoder12_stream
  import decoder_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEFAULT,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [(1<<CODE_W)-1:0] out_onehot,
  output logic [CNT_W-1:0]     sym_count
);

  localparam int               OH_W    = 1 << CODE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              run_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              w_full, w_empty, w_push, w_pop;
  logic [CODE_W-1:0] w_head;

  // Registered flag keeps in_ready low while in reset without a
  // combinational path from the reset pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign in_ready  = run_q && en && !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (in_code),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    out_onehot = '0;
    if (!w_empty) out_onehot = OH_W'(onehot(32'(w_head)));
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                           cnt_d = '0;
    else if (w_pop && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sym_count = cnt_q;

endmodule
`default_nettype wire
